// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding, word size and word-index helper for the data memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Byte address -> word index, wrapped to a power-of-two depth.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned depth);
        return (byte_addr >> $clog2(WORD_BYTES)) & (depth - 1);
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// rtl/dmem_word_array.sv - DEPTH x 32 storage, synchronous write, registered read, no reset
//
// Ports:
//   clk    in   clock
//   we     in   write enable; wdata stored at widx on the rising edge
//   widx   in   write word index
//   wdata  in   write data
//   ridx   in   read word index
//   re     in   read enable; rdata loads storage[ridx] on the rising edge
//   rdata  out  registered read data (holds between reads)
module dmem_word_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    input  logic             re,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - multi-cycle data memory responder with wait states, stall and error reporting
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   mem_read    in   load request
//   mem_write   in   store request
//   addr        in   byte address
//   write_data  in   store data
//   read_data   out  load data, nonzero only in the DONE cycle of a good load
//   mem_stall   out  request present and not yet in its DONE cycle
//   mem_error   out  pulse in DONE for a misaligned or read+write request
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        mem_error
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  lat_idx_q;
    logic [31:0]       lat_wdata_q;
    logic              lat_read_q;
    logic              lat_write_q;
    logic              lat_err_q;

    logic              req;
    logic              accept;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic              rd_en;
    logic              wr_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [31:0]       arr_rdata;

    assign req     = mem_read | mem_write;
    assign acc_idx = IDX_W'(word_index(addr, DEPTH));
    assign acc_err = (addr[1:0] != 2'b00) | (mem_read & mem_write);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        // No wait states: the read must use the live inputs,
                        // since the latches only load on this same edge.
                        state_d = DONE;
                        rd_en   = mem_read & ~acc_err;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // Pipeline flush: abandon the access silently.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    rd_en   = lat_read_q & ~lat_err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                wr_en   = lat_write_q & ~lat_err_q;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_idx_q   <= '0;
            lat_wdata_q <= '0;
            lat_read_q  <= 1'b0;
            lat_write_q <= 1'b0;
            lat_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_idx_q   <= acc_idx;
                lat_wdata_q <= write_data;
                lat_read_q  <= mem_read;
                lat_write_q <= mem_write;
                lat_err_q   <= acc_err;
            end
        end
    end

    assign rd_idx = (state_q == IDLE) ? acc_idx : lat_idx_q;

    dmem_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .widx  (lat_idx_q),
        .wdata (lat_wdata_q),
        .ridx  (rd_idx),
        .re    (rd_en),
        .rdata (arr_rdata)
    );

    // The array register has no reset; gating by state makes read_data zero
    // outside the DONE cycle of a good load, including right after reset.
    assign read_data = (state_q == DONE && lat_read_q && !lat_err_q) ? arr_rdata : 32'd0;
    assign mem_stall = req & (state_q != DONE);
    assign mem_error = (state_q == DONE) & lat_err_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - self-checking bench for dmem_wait_responder (WAIT_STATES 2 and 0)
module tb_dmem_wait_responder;

    localparam int DEPTH = 256;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       mem_read, mem_write, mem_stall, mem_error;
    logic [1:0][31:0] addr, write_data, read_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int wait_of [2] = '{2, 0};

    logic [31:0] model_mem [2][DEPTH];
    bit          model_vld [2][DEPTH];

    dmem_wait_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read[0]),
        .mem_write  (mem_write[0]),
        .addr       (addr[0]),
        .write_data (write_data[0]),
        .read_data  (read_data[0]),
        .mem_stall  (mem_stall[0]),
        .mem_error  (mem_error[0])
    );

    dmem_wait_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read[1]),
        .mem_write  (mem_write[1]),
        .addr       (addr[1]),
        .write_data (write_data[1]),
        .read_data  (read_data[1]),
        .mem_stall  (mem_stall[1]),
        .mem_error  (mem_error[1])
    );

    function automatic int exp_idx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic bit exp_err(input logic [31:0] a, input bit rd, input bit wr);
        return (a % 4 != 0) || (rd && wr);
    endfunction

    task automatic model_store(input int k, input logic [31:0] a, input logic [31:0] d);
        model_mem[k][exp_idx(a)] = d;
        model_vld[k][exp_idx(a)] = 1'b1;
    endtask

    task automatic drop(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_read   = '0;
            mem_write  = '0;
            addr       = '0;
            write_data = '0;
        end
    endtask

    // Presents one request on instance k and observes it until DONE, or until
    // it is aborted (request dropped or reset pulsed) at cycle abort_at.
    task automatic run_req(input int k, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input int abort_at, input bit abort_by_reset,
                           output int n_stall, output logic [31:0] o_data,
                           output logic o_err, output logic o_stall,
                           output int o_cyc, output bit side_bad,
                           output bit timed_out);
        int c;
        n_stall   = 0;
        side_bad  = 1'b0;
        timed_out = 1'b1;
        o_data    = '0;
        o_err     = 1'b0;
        o_stall   = 1'b0;
        o_cyc     = 0;
        c         = 0;
        @(negedge clk);
        mem_read[k]   = rd;
        mem_write[k]  = wr;
        addr[k]       = a;
        write_data[k] = d;
        while (c < 40) begin
            #1;
            if (mem_stall[k] !== 1'b1) begin
                o_data    = read_data[k];
                o_err     = mem_error[k];
                o_stall   = mem_stall[k];
                o_cyc     = cyc;
                timed_out = 1'b0;
                break;
            end
            n_stall++;
            if (read_data[k] !== 32'd0 || mem_error[k] !== 1'b0) side_bad = 1'b1;
            @(negedge clk);
            c++;
            if (c == abort_at) begin
                mem_read[k]  = 1'b0;
                mem_write[k] = 1'b0;
                if (abort_by_reset) rst_n = 1'b0;
                #1;
                o_data    = read_data[k];
                o_err     = mem_error[k];
                o_stall   = mem_stall[k];
                timed_out = 1'b0;
                if (abort_by_reset) begin
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drop(1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (mem_stall[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_stall[%0d]: got %b expected 0", k, mem_stall[k]);
            end
            checks++;
            if (mem_error[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_error[%0d]: got %b expected 0", k, mem_error[k]);
            end
            checks++;
            if (read_data[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_read_data[%0d]: got %h expected 0", k, read_data[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drop(1);
    endtask

    // Runs a clean access on instance k and checks stall length, error and data.
    task automatic test_access(input string name, input int k, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] want_data, input bit want_err,
                               output int done_cyc);
        int ns; logic [31:0] od; logic oe, os; bit sb, to;
        run_req(k, rd, wr, a, d, -1, 1'b0, ns, od, oe, os, done_cyc, sb, to);
        checks++;
        if (to || sb || ns != wait_of[k] + 1) begin
            errors++;
            $display("FAIL %s_stall: got %0d stall cycles (timeout=%0d side=%0d) expected %0d",
                     name, ns, to, sb, wait_of[k] + 1);
        end
        checks++;
        if (oe !== want_err) begin
            errors++;
            $display("FAIL %s_error: got %b expected %b", name, oe, want_err);
        end
        checks++;
        if (od !== want_data) begin
            errors++;
            $display("FAIL %s_data: got %h expected %h", name, od, want_data);
        end
        if (wr && !exp_err(a, rd, wr)) model_store(k, a, d);
    endtask

    task automatic test_store_load();
        int dc;
        test_access("store_10", 0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, dc);
        drop(1);
        test_access("load_10", 0, 1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, dc);
        drop(1);
    endtask

    task automatic test_back_to_back();
        int dc0, dc1;
        logic [31:0] v0, v1;
        v0 = $urandom;
        v1 = $urandom;
        test_access("b2b_store0", 1, 1'b0, 1'b1, 32'h0, v0, 32'd0, 1'b0, dc0);
        test_access("b2b_store4", 1, 1'b0, 1'b1, 32'h4, v1, 32'd0, 1'b0, dc1);
        test_access("b2b_load0",  1, 1'b1, 1'b0, 32'h0, 32'd0, v0, 1'b0, dc0);
        test_access("b2b_load4",  1, 1'b1, 1'b0, 32'h4, 32'd0, v1, 1'b0, dc1);
        checks++;
        if (dc1 - dc0 != 2) begin
            errors++;
            $display("FAIL b2b_done_spacing: got %0d cycles expected 2", dc1 - dc0);
        end
        drop(1);
    endtask

    task automatic test_misaligned();
        int dc;
        test_access("store_12_misaligned", 0, 1'b0, 1'b1, 32'h12, 32'h12345678, 32'd0, 1'b1, dc);
        drop(1);
        test_access("load_10_after_misaligned", 0, 1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, dc);
        drop(1);
    endtask

    task automatic test_rw_conflict();
        int dc;
        logic [31:0] v;
        v = $urandom;
        test_access("store_20", 0, 1'b0, 1'b1, 32'h20, v, 32'd0, 1'b0, dc);
        drop(1);
        test_access("rw_conflict_20", 0, 1'b1, 1'b1, 32'h20, ~v, 32'd0, 1'b1, dc);
        drop(1);
        test_access("load_20_after_conflict", 0, 1'b1, 1'b0, 32'h20, 32'd0, v, 1'b0, dc);
        drop(1);
    endtask

    task automatic test_abort();
        int dc, ns; logic [31:0] od; logic oe, os; bit sb, to;
        logic [31:0] v0;
        v0 = $urandom;
        test_access("store_30", 0, 1'b0, 1'b1, 32'h30, v0, 32'd0, 1'b0, dc);
        drop(1);
        run_req(0, 1'b0, 1'b1, 32'h30, ~v0, 1, 1'b0, ns, od, oe, os, dc, sb, to);
        checks++;
        if (os !== 1'b0 || oe !== 1'b0 || od !== 32'd0) begin
            errors++;
            $display("FAIL flush_outputs: got stall=%b err=%b data=%h expected 0 0 0", os, oe, od);
        end
        drop(1);
        test_access("load_30_after_flush", 0, 1'b1, 1'b0, 32'h30, 32'd0, v0, 1'b0, dc);
        drop(1);
        run_req(0, 1'b0, 1'b1, 32'h30, v0 ^ 32'h5A5A_5A5A, 2, 1'b1, ns, od, oe, os, dc, sb, to);
        checks++;
        if (os !== 1'b0 || oe !== 1'b0 || od !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_wait_outputs: got stall=%b err=%b data=%h expected 0 0 0", os, oe, od);
        end
        drop(1);
        test_access("load_30_after_reset", 0, 1'b1, 1'b0, 32'h30, 32'd0, v0, 1'b0, dc);
        drop(1);
    endtask

    task automatic test_wrap();
        int dc;
        logic [31:0] v;
        v = $urandom;
        test_access("store_400", 0, 1'b0, 1'b1, 32'h400, v, 32'd0, 1'b0, dc);
        drop(1);
        test_access("load_0_wrapped", 0, 1'b1, 1'b0, 32'h0, 32'd0, v, 1'b0, dc);
        drop(1);
    endtask

    task automatic test_random(input int k);
        int ns, dc, ab, idx, r;
        logic [31:0] a, d, od;
        logic oe, os;
        bit sb, to, rd, wr, e;
        for (int i = 0; i < 60; i++) begin
            r  = int'($urandom_range(0, 15));
            rd = (r < 7) || (r == 15);
            wr = (r >= 7);
            a  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            d  = $urandom;
            ab = -1;
            if (wait_of[k] > 0 && $urandom_range(0, 5) == 0) ab = int'($urandom_range(1, wait_of[k]));
            e   = exp_err(a, rd, wr);
            idx = exp_idx(a);
            run_req(k, rd, wr, a, d, ab, 1'b0, ns, od, oe, os, dc, sb, to);
            if (ab > 0) begin
                checks++;
                if (os !== 1'b0 || oe !== 1'b0 || od !== 32'd0) begin
                    errors++;
                    $display("FAIL rnd%0d_%0d_abort: got stall=%b err=%b data=%h expected 0 0 0", k, i, os, oe, od);
                end
            end else begin
                checks++;
                if (to || sb || ns != wait_of[k] + 1) begin
                    errors++;
                    $display("FAIL rnd%0d_%0d_stall: got %0d expected %0d", k, i, ns, wait_of[k] + 1);
                end
                checks++;
                if (oe !== e) begin
                    errors++;
                    $display("FAIL rnd%0d_%0d_error: got %b expected %b", k, i, oe, e);
                end
                if (rd && !e) begin
                    if (model_vld[k][idx]) begin
                        checks++;
                        if (od !== model_mem[k][idx]) begin
                            errors++;
                            $display("FAIL rnd%0d_%0d_load: got %h expected %h", k, i, od, model_mem[k][idx]);
                        end
                    end
                end else begin
                    checks++;
                    if (od !== 32'd0) begin
                        errors++;
                        $display("FAIL rnd%0d_%0d_data_zero: got %h expected 0", k, i, od);
                    end
                end
                if (wr && !e) model_store(k, a, d);
            end
            drop(int'($urandom_range(0, 1)));
        end
        drop(1);
    endtask

    initial begin
        mem_read   = '0;
        mem_write  = '0;
        addr       = '0;
        write_data = '0;
        rst_n      = 1'b1;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_misaligned();
        test_rw_conflict();
        test_abort();
        test_wrap();
        test_random(0);
        test_random(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
